// File: rtl/seg_digit_sequencer.sv
// seg_digit_sequencer: start/stop/clear/load digit stepper driving the 7-seg decoder input.
// Define SEG_BLINK_EN to blink the display (4'hF) at the prescaler rate while paused.
module seg_digit_sequencer #(
  parameter int unsigned PRESCALE = 10_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       dir,
  input  logic       load_en,
  input  logic [3:0] load_val,
  output logic [3:0] counter,
  output logic       tick,
  output logic       wrap,
  output logic [1:0] state
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} st_t;
  localparam logic [23:0] LAST = 24'(PRESCALE - 1);
  st_t st, st_n;
  logic [3:0] digit, digit_n;
  logic [23:0] pre, pre_n;
  logic phase_n, counting, roll, step, vload, acc_start;
`ifdef SEG_BLINK_EN
  logic phase;
  assign counting = st == RUN || st == PAUSE;
  assign phase_n = st_n != PAUSE ? 1'b0 : (st == PAUSE && roll) ? ~phase : phase;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) phase <= 1'b0;
    else phase <= phase_n;
`else
  assign counting = st == RUN;
  assign phase_n = 1'b0;
`endif
  always_comb begin
    st_n = st == IDLE  ? (start && !stop ? RUN : IDLE) :
           st == RUN   ? (stop ? PAUSE : RUN) :
           st == PAUSE ? (stop ? IDLE : start ? RUN : PAUSE) : IDLE;
    vload = load_en && load_val <= 4'd9;
    acc_start = st_n == RUN && st != RUN;
    roll = counting && pre == LAST;
    // an invalid load still swallows the step
    step = st == RUN && roll && !clear && !load_en;
    digit_n = clear ? 4'd0 : vload ? load_val : !step ? digit :
              dir ? (digit == 4'd0 ? 4'd9 : digit - 4'd1) : (digit == 4'd9 ? 4'd0 : digit + 4'd1);
    pre_n = (st == IDLE || acc_start || clear || vload || roll) ? 24'd0 : counting ? pre + 24'd1 : pre;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      digit <= 4'd0;
      pre <= 24'd0;
      counter <= 4'hF;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      st <= st_n;
      digit <= digit_n;
      pre <= pre_n;
      counter <= (st_n == IDLE || phase_n) ? 4'hF : digit_n;
      tick <= step;
      wrap <= step && (dir ? digit == 4'd0 : digit == 4'd9);
    end
  assign state = st;
endmodule

// File: tb/tb_seg_digit_sequencer.sv
// tb_seg_digit_sequencer: reference model compared every cycle plus hand-computed checkpoints.
module tb_seg_digit_sequencer;
  localparam int P = 4;
`ifdef SEG_BLINK_EN
  localparam bit BLINK = 1;
`else
  localparam bit BLINK = 0;
`endif
  logic clk = 0, rst_n = 1, start = 0, stop = 0, clear = 0, dir = 0, load_en = 0;
  logic [3:0] load_val = 0;
  logic [3:0] counter;
  logic tick, wrap;
  logic [1:0] state;
  int checks = 0, errors = 0, wraps;
  bit go = 0;
  int ms = 0, md = 0, me = 0, mp = 0, ec = 15, et = 0, ew = 0;
  int ns;
  bit roll, stp, vload, acc;

  seg_digit_sequencer #(.PRESCALE(P)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear), .dir(dir),
    .load_en(load_en), .load_val(load_val), .counter(counter), .tick(tick), .wrap(wrap), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", n, $time, a, e);
    end
  endtask

  // reference: state as an int, digit mod 10, elapsed cycles in the current period
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms = 0; md = 0; me = 0; mp = 0; ec = 15; et = 0; ew = 0;
    end else begin
      ns = ms;
      if (ms == 0 && start && !stop) ns = 1;
      else if (ms == 1 && stop) ns = 2;
      else if (ms == 2) ns = stop ? 0 : start ? 1 : 2;
      acc = ns == 1 && ms != 1;
      vload = load_en && load_val < 10;
      roll = (ms == 1 || (BLINK && ms == 2)) && me == P - 1;
      stp = ms == 1 && roll && !clear && !load_en;
      et = stp;
      ew = stp && (dir ? md == 0 : md == 9);
      if (clear) md = 0;
      else if (vload) md = load_val;
      else if (stp) md = (md + (dir ? 9 : 1)) % 10;
      if (ns != 2) mp = 0;
      else if (ms == 2 && roll) mp = 1 - mp;
      if (ms == 0 || acc || clear || vload || roll) me = 0;
      else if (ms == 1 || (BLINK && ms == 2)) me = me + 1;
      ms = ns;
      ec = (ms == 0 || mp == 1) ? 15 : md;
    end
  end

  always @(negedge clk) if (go) begin
    chk("counter", counter, ec);
    chk("tick", tick, et);
    chk("wrap", wrap, ew);
    chk("state", state, ms);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_count(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1);
      if (wrap) wraps++;
    end
  endtask

  initial begin
    #1 rst_n = 0;
    go = 1;
    cyc(2);
    rst_n = 1;
    cyc(20);
    chk("idle_counter", counter, 15);
    chk("idle_state", state, 0);
    start = 1; cyc(1); start = 0;
    chk("run_state", state, 1);
    chk("run_counter0", counter, 0);
    wraps = 0;
    cyc(3);
    chk("no_early_tick", tick, 0);
    run_count(1);
    chk("first_step", counter, 1);
    chk("first_tick", tick, 1);
    run_count(40);
    chk("up_end", counter, 1);
    chk("up_wraps", wraps, 1);
    load_en = 1; load_val = 3; dir = 1; cyc(1); load_en = 0;
    chk("load3", counter, 3);
    wraps = 0;
    run_count(16);
    chk("down_end", counter, 9);
    chk("down_wraps", wraps, 1);
    stop = 1; cyc(1); stop = 0;
    chk("pause_state", state, 2);
    cyc(20);
`ifndef SEG_BLINK_EN
    chk("pause_steady", counter, 9);
`endif
    start = 1; cyc(1); start = 0;
    chk("resume_state", state, 1);
    cyc(3);
    chk("resume_hold", counter, 9);
    cyc(1);
    chk("resume_step", counter, 8);
    chk("resume_tick", tick, 1);
    cyc(3);
    clear = 1; load_en = 1; load_val = 7; cyc(1); clear = 0;
    chk("clear_wins", counter, 0);
    chk("clear_no_tick", tick, 0);
    load_val = 12; cyc(1); load_en = 0;
    chk("bad_load", counter, 0);
    stop = 1; cyc(1); stop = 0;
    chk("pause2", state, 2);
    start = 1; stop = 1; cyc(1); start = 0; stop = 0;
    chk("both_idle_state", state, 0);
    chk("both_idle_counter", counter, 15);
    load_en = 1; load_val = 5; cyc(1); load_en = 0;
    chk("idle_load_blank", counter, 15);
    dir = 0;
    start = 1; cyc(1); start = 0;
    chk("idle_load_shown", counter, 5);
    cyc(4);
    chk("pre_reset_tick", tick, 1);
    #2 rst_n = 0;
    #1;
    chk("async_counter", counter, 15);
    chk("async_tick", tick, 0);
    chk("async_state", state, 0);
    cyc(2);
    rst_n = 1;
    cyc(6);
    chk("post_reset_idle", counter, 15);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
